// File: rtl/rx_line_assembler.sv
// rx_line_assembler
//   Receive-side line editor. Pops bytes from the uart_rx FIFO and echoes
//   accepted keystrokes to uart_tx. It builds one line of up to MAX_LEN 7-bit
//   characters, with backspace editing. On CR it presents the line to a
//   consumer and holds it until that consumer acknowledges it.
//
// Ports
//   clock, reset         : system clock (rising edge), async active-low reset
//   rx_data              : head byte of the uart_rx FIFO
//   rx_data_present      : uart_rx FIFO non-empty
//   read_from_uart       : one-cycle pop strobe to uart_rx
//   tx_full              : uart_tx buffer full, stalls the echo
//   echo_data/echo_write : echoed byte and its one-cycle write strobe
//   rd_address/rd_data   : registered random-access read of the line buffer
//   line_ready           : a complete line is held
//   line_length          : character count of the held line
//   line_ack             : consumer releases the held line
//   overflow             : sticky, a character was dropped on a full buffer
//
// MAX_LEN must be less than 2**ADDR_BITS so that a full count fits in the
// length field.
module rx_line_assembler #(
    parameter int ADDR_BITS = 5,
    parameter int MAX_LEN   = 21
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_data_present,
    output logic                 read_from_uart,
    input  logic                 tx_full,
    output logic [7:0]           echo_data,
    output logic                 echo_write,
    input  logic [ADDR_BITS-1:0] rd_address,
    output logic [6:0]           rd_data,
    output logic                 line_ready,
    output logic [ADDR_BITS-1:0] line_length,
    input  logic                 line_ack,
    output logic                 overflow
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLASSIFY = 2'd1;
    localparam logic [1:0] S_ECHO     = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

    localparam logic [ADDR_BITS-1:0] MAX_CNT = ADDR_BITS'(MAX_LEN);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;
    localparam logic [7:0] CH_BEL = 8'h07;

    logic [1:0]           state;
    logic [7:0]           char_reg;
    logic [7:0]           echo_pending;
    logic                 echo_is_cr;
    logic [ADDR_BITS-1:0] count;
    logic [6:0]           buffer [0:MAX_LEN-1];

    logic is_cr;
    logic is_bs;
    logic is_printable;
    logic has_room;
    logic buf_we;

    assign is_cr        = (char_reg == CH_CR);
    assign is_bs        = (char_reg == CH_BS) || (char_reg == CH_DEL);
    assign is_printable = (char_reg >= 8'h20) && (char_reg <= 8'h7E);
    assign has_room     = (count < MAX_CNT);
    assign buf_we       = (state == S_CLASSIFY) && is_printable && has_room;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            char_reg       <= '0;
            echo_pending   <= '0;
            echo_is_cr     <= 1'b0;
            count          <= '0;
            read_from_uart <= 1'b0;
            echo_write     <= 1'b0;
            echo_data      <= '0;
            line_ready     <= 1'b0;
            line_length    <= '0;
            overflow       <= 1'b0;
        end else begin
            // The strobes default low, so each one lasts exactly one cycle.
            read_from_uart <= 1'b0;
            echo_write     <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The pop is asserted during CLASSIFY. The FIFO head then
                    // advances before we can be back in IDLE.
                    if (rx_data_present) begin
                        char_reg       <= rx_data;
                        read_from_uart <= 1'b1;
                        state          <= S_CLASSIFY;
                    end
                end

                S_CLASSIFY: begin
                    state      <= S_IDLE;
                    echo_is_cr <= 1'b0;
                    if (is_cr) begin
                        echo_pending <= CH_CR;
                        echo_is_cr   <= 1'b1;
                        state        <= S_ECHO;
                    end else if (is_bs) begin
                        if (count != '0) begin
                            count        <= count - 1'b1;
                            echo_pending <= CH_BS;
                            state        <= S_ECHO;
                        end
                    end else if (is_printable) begin
                        state <= S_ECHO;
                        if (has_room) begin
                            count        <= count + 1'b1;
                            echo_pending <= char_reg;
                        end else begin
                            overflow     <= 1'b1;
                            echo_pending <= CH_BEL;
                        end
                    end
                    // LF, other control codes and bytes >= 0x80 fall through
                    // to IDLE silently.
                end

                S_ECHO: begin
                    if (!tx_full) begin
                        echo_write <= 1'b1;
                        echo_data  <= echo_pending;
                        if (echo_is_cr) begin
                            line_ready  <= 1'b1;
                            line_length <= count;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_HOLD: begin
                    // The FIFO is left untouched here, so keystrokes queue up
                    // in uart_rx until the consumer lets go of the line.
                    if (line_ack) begin
                        line_ready  <= 1'b0;
                        line_length <= '0;
                        count       <= '0;
                        overflow    <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the line buffer has no reset. Its contents are meaningless until
    // they are written, and leaving out the reset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buffer[count] <= char_reg[6:0];
        end
    end

    // Registered read port. A write to the same address in the same cycle
    // returns the old data. Addresses beyond the buffer read as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_address < MAX_CNT) begin
            rd_data <= buffer[rd_address];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_rx_line_assembler.sv
// Self-checking bench for rx_line_assembler. A small uart_rx FIFO model feeds
// the DUT. The stimulus pushes the expected echo bytes into a scoreboard queue.
// A monitor pops that queue on every echo_write strobe.
module tb_rx_line_assembler;

    localparam int ADDR_BITS = 5;
    localparam int MAX_LEN   = 21;

    logic                 clock;
    logic                 reset;
    logic [7:0]           rx_data;
    logic                 rx_data_present;
    logic                 read_from_uart;
    logic                 tx_full;
    logic [7:0]           echo_data;
    logic                 echo_write;
    logic [ADDR_BITS-1:0] rd_address;
    logic [6:0]           rd_data;
    logic                 line_ready;
    logic [ADDR_BITS-1:0] line_length;
    logic                 line_ack;
    logic                 overflow;

    rx_line_assembler #(.ADDR_BITS(ADDR_BITS), .MAX_LEN(MAX_LEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_data_present (rx_data_present),
        .read_from_uart  (read_from_uart),
        .tx_full         (tx_full),
        .echo_data       (echo_data),
        .echo_write      (echo_write),
        .rd_address      (rd_address),
        .rd_data         (rd_data),
        .line_ready      (line_ready),
        .line_length     (line_length),
        .line_ack        (line_ack),
        .overflow        (overflow)
    );

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int echo_cnt = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // uart_rx FIFO model. It pops on the strobe and refreshes its head a
    // little after each clock edge.
    initial begin
        rx_data         = 8'h00;
        rx_data_present = 1'b0;
    end
    always begin
        @(posedge clock);
        if (read_from_uart) begin
            pops++;
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
        #1;
        rx_data_present = (rx_q.size() != 0);
        rx_data         = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        @(negedge clock);
        #1;
        rx_data_present = (rx_q.size() != 0);
        rx_data         = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // Echo scoreboard monitor
    always @(negedge clock) begin
        if (reset && echo_write) begin
            echo_cnt++;
            check("echo/read overlap", 32'(read_from_uart), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected echo: got 0x%0h, expected none", echo_data);
            end else begin
                check("echo_data", 32'(echo_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b, input bit has_echo, input logic [7:0] e);
        rx_q.push_back(b);
        if (has_echo) exp_q.push_back(e);
    endtask

    task automatic wait_line_ready(input int budget);
        int n = 0;
        while (!line_ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("line_ready reached", 32'(line_ready), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (rx_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check("fifo drained", 32'(rx_q.size()), 32'd0);
    endtask

    task automatic read_check(input logic [ADDR_BITS-1:0] a, input logic [6:0] e, input string name);
        rd_address = a;
        @(negedge clock);
        check(name, 32'(rd_data), 32'(e));
    endtask

    task automatic ack_line();
        line_ack = 1'b1;
        @(negedge clock);
        line_ack = 1'b0;
        check("line_ready after ack", 32'(line_ready), 32'd0);
        check("line_length after ack", 32'(line_length), 32'd0);
        check("overflow after ack", 32'(overflow), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " read_from_uart"}, 32'(read_from_uart), 32'd0);
        check({tag, " echo_write"},     32'(echo_write),     32'd0);
        check({tag, " echo_data"},      32'(echo_data),      32'd0);
        check({tag, " rd_data"},        32'(rd_data),        32'd0);
        check({tag, " line_ready"},     32'(line_ready),     32'd0);
        check({tag, " line_length"},    32'(line_length),    32'd0);
        check({tag, " overflow"},       32'(overflow),       32'd0);
    endtask

    initial begin
        int p0;
        int e0;
        logic [7:0] ch;

        reset      = 1'b0;
        tx_full    = 1'b0;
        line_ack   = 1'b0;
        rd_address = '0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // "AB" CR
        p0 = pops;
        push(8'h41, 1, 8'h41);
        push(8'h42, 1, 8'h42);
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(100);
        check("AB pops", 32'(pops - p0), 32'd3);
        check("AB length", 32'(line_length), 32'd2);
        check("AB overflow", 32'(overflow), 32'd0);
        read_check(5'd0, 7'h41, "AB rd0");
        read_check(5'd1, 7'h42, "AB rd1");
        read_check(5'd21, 7'h00, "rd addr 21");
        read_check(5'd31, 7'h00, "rd addr 31");
        ack_line();

        // Backspace at count 0, then "ABC" BS "D" CR
        push(8'h7F, 0, 8'h00);
        push(8'h41, 1, 8'h41);
        push(8'h42, 1, 8'h42);
        push(8'h43, 1, 8'h43);
        push(8'h08, 1, 8'h08);
        push(8'h44, 1, 8'h44);
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(200);
        check("edit length", 32'(line_length), 32'd3);
        read_check(5'd0, 7'h41, "edit rd0");
        read_check(5'd1, 7'h42, "edit rd1");
        read_check(5'd2, 7'h44, "edit rd2");
        ack_line();

        // 23 printable characters then CR: the last two overflow with BEL
        for (int i = 0; i < 23; i++) begin
            ch = 8'h61 + 8'(i);
            push(ch, 1, (i < MAX_LEN) ? ch : 8'h07);
        end
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(400);
        check("full length", 32'(line_length), 32'd21);
        check("full overflow", 32'(overflow), 32'd1);
        read_check(5'd0, 7'h61, "full rd0");
        read_check(5'd20, 7'h75, "full rd20");
        ack_line();

        // tx_full stall during the echo of 'X'
        tx_full = 1'b1;
        p0 = pops;
        e0 = echo_cnt;
        push(8'h58, 1, 8'h58);
        push(8'h51, 1, 8'h51);
        repeat (50) @(negedge clock);
        check("stall pops", 32'(pops - p0), 32'd1);
        check("stall echoes", 32'(echo_cnt - e0), 32'd0);
        tx_full = 1'b0;
        @(negedge clock);
        check("stall release echo_write", 32'(echo_write), 32'd1);
        check("stall release echo_data", 32'(echo_data), 32'h58);
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(100);
        check("XQ length", 32'(line_length), 32'd2);

        // 'Z' arrives while the line is held
        p0 = pops;
        push(8'h5A, 1, 8'h5A);
        repeat (20) @(negedge clock);
        check("hold pops", 32'(pops - p0), 32'd0);
        check("hold line_ready", 32'(line_ready), 32'd1);
        ack_line();
        wait_drain(50);
        check("Z pops", 32'(pops - p0), 32'd1);
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(100);
        check("Z length", 32'(line_length), 32'd1);
        read_check(5'd0, 7'h5A, "Z rd0");
        ack_line();

        // Reset while an echo is stalled
        tx_full = 1'b1;
        push(8'h4D, 0, 8'h00);
        wait_drain(50);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid reset");
        @(negedge clock);
        reset   = 1'b1;
        tx_full = 1'b0;
        p0 = pops;
        push(8'h0A, 0, 8'h00);
        push(8'h85, 0, 8'h00);
        push(8'h0D, 1, 8'h0D);
        wait_line_ready(100);
        check("post-reset pops", 32'(pops - p0), 32'd3);
        check("post-reset length", 32'(line_length), 32'd0);
        check("post-reset overflow", 32'(overflow), 32'd0);
        ack_line();

        repeat (4) @(negedge clock);
        check("echo queue empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
